dma_axi_wr_master: RTL and testbench

- Write-side AXI4 master that consumes the burst requests issued by the DMA write streamer (addr/alen/size/strb/mode with valid/ready).
- Converts each request into an AW transfer, streams the matching W beats from the DMA data buffer, and retires B responses.
- Sits between the write streamer and the AXI master port of the DMA. It reports idle and error status back to the DMA FSM/CSRs.

---
 rtl/dma_axi_wr_master.sv | 169 ++++++++++++++++
 tb/tb_dma_axi_wr_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_axi_wr_master.sv
// AXI4 write master for the DMA: forwards streamer requests onto AW, streams
// buffer data onto W using a small burst queue, and retires B responses.
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 32
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif

module dma_axi_wr_master #(
    parameter int ADDR_WIDTH      = `DMA_ADDR_WIDTH,
    parameter int DATA_WIDTH      = `DMA_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [7:0]              req_alen_i,
    input  logic [2:0]              req_size_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic                    req_mode_i,
    output logic                    req_ready_o,
    input  logic                    dma_abort_i,
    input  logic                    err_clr_i,
    input  logic [DATA_WIDTH-1:0]   buf_data_i,
    input  logic                    buf_valid_i,
    output logic                    buf_ready_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic [7:0]              awlen_o,
    output logic [2:0]              awsize_o,
    output logic [1:0]              awburst_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    output logic                    idle_o,
    output logic                    err_o
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic {W_IDLE, W_DATA} w_state_e;

    w_state_e        state_q, state_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]   cur_strb_q, cur_strb_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            err_q, err_d;

    logic [7:0]      alen_mem [MAX_OUTSTANDING];
    logic [SW-1:0]   strb_mem [MAX_OUTSTANDING];

    logic            q_empty, q_full, can_issue, aw_hs, b_hs, w_hs, pop;

    // Extra pointer bit distinguishes full from empty.
    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // AW is a zero-latency pass-through; the streamer holds the request.
    assign can_issue   = ~dma_abort_i & (outst_q < OUT_MAX) & ~q_full;
    assign awvalid_o   = req_valid_i & can_issue;
    assign awaddr_o    = req_addr_i;
    assign awlen_o     = req_alen_i;
    assign awsize_o    = req_size_i;
    assign awburst_o   = {1'b0, req_mode_i};
    assign aw_hs       = awvalid_o & awready_i;
    assign req_ready_o = aw_hs;

    assign bready_o = (outst_q != '0);
    assign b_hs     = bvalid_i & bready_o;

    assign wdata_o = buf_data_i;
    assign wstrb_o = cur_strb_q;
    assign w_hs    = wvalid_o & wready_i;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        cur_strb_d  = cur_strb_q;
        pop         = 1'b0;
        wvalid_o    = 1'b0;
        buf_ready_o = 1'b0;
        wlast_o     = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    beat_cnt_d = alen_mem[rd_ptr_q[PW-1:0]];
                    cur_strb_d = strb_mem[rd_ptr_q[PW-1:0]];
                    state_d    = W_DATA;
                end
            end
            W_DATA: begin
                wvalid_o    = buf_valid_i;
                buf_ready_o = wready_i;
                wlast_o     = (beat_cnt_q == 8'd0);
                if (w_hs) begin
                    if (beat_cnt_q != 8'd0) begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end else if (!q_empty) begin
                        // Chain straight into the next queued burst.
                        pop        = 1'b1;
                        beat_cnt_d = alen_mem[rd_ptr_q[PW-1:0]];
                        cur_strb_d = strb_mem[rd_ptr_q[PW-1:0]];
                    end else begin
                        state_d = W_IDLE;
                    end
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PW+1)'(aw_hs);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
        outst_d  = outst_q;
        case ({aw_hs, b_hs})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
        // A new error in the same cycle as the clear takes priority.
        err_d = (err_q & ~err_clr_i) | (b_hs & (bresp_i != 2'b00));
    end

    assign idle_o = (outst_q == '0) & q_empty & (state_q == W_IDLE) & ~awvalid_o;
    assign err_o  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= W_IDLE;
            beat_cnt_q <= '0;
            cur_strb_q <= '0;
            outst_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            cur_strb_q <= cur_strb_d;
            outst_q    <= outst_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            alen_mem[wr_ptr_q[PW-1:0]] <= req_alen_i;
            strb_mem[wr_ptr_q[PW-1:0]] <= req_strb_i;
        end
    end

endmodule

// File: tb/tb_dma_axi_wr_master.sv
// Directed bench for dma_axi_wr_master: linear steps with immediate assertions.
module tb_dma_axi_wr_master;

    logic        clk, rst;
    logic        req_valid_i, req_mode_i, req_ready_o, dma_abort_i, err_clr_i;
    logic [31:0] req_addr_i, buf_data_i, awaddr_o, wdata_o;
    logic [7:0]  req_alen_i, awlen_o;
    logic [2:0]  req_size_i, awsize_o;
    logic [3:0]  req_strb_i, wstrb_o;
    logic        buf_valid_i, buf_ready_o, awvalid_o, awready_i;
    logic [1:0]  awburst_o, bresp_i;
    logic        wlast_o, wvalid_o, wready_i, bvalid_i, bready_o, idle_o, err_o;

    int checks = 0;
    int failures = 0;

    dma_axi_wr_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_alen_i(req_alen_i),
        .req_size_i(req_size_i), .req_strb_i(req_strb_i), .req_mode_i(req_mode_i),
        .req_ready_o(req_ready_o), .dma_abort_i(dma_abort_i), .err_clr_i(err_clr_i),
        .buf_data_i(buf_data_i), .buf_valid_i(buf_valid_i), .buf_ready_o(buf_ready_o),
        .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .idle_o(idle_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [7:0] l,
                           input logic [3:0] s, input logic m);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_alen_i  = l;
        req_size_i  = 3'd2;
        req_strb_i  = s;
        req_mode_i  = m;
    endtask

    task automatic b_ok();
        bvalid_i = 1'b1;
        bresp_i  = 2'b00;
        step();
        bvalid_i = 1'b0;
    endtask

    int bv[12] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1};
    int wr[12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [31:0] dseq[4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        int idx;
        rst = 1'b1;
        req_valid_i = 0; req_addr_i = 0; req_alen_i = 0; req_size_i = 0;
        req_strb_i = 0; req_mode_i = 0; dma_abort_i = 0; err_clr_i = 0;
        buf_data_i = 0; buf_valid_i = 0; awready_i = 1; wready_i = 1;
        bresp_i = 0; bvalid_i = 0;
        #1;
        check("rst_awvalid", awvalid_o, 0);
        check("rst_wvalid", wvalid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_buf_ready", buf_ready_o, 0);
        check("rst_bready", bready_o, 0);
        check("rst_idle", idle_o, 1);
        check("rst_err", err_o, 0);
        step(); step();
        rst = 1'b0;
        step();

        // Single INCR burst, 4 beats
        set_req(32'h1000, 8'd3, 4'hF, 1'b1);
        buf_valid_i = 1'b1;
        #1;
        check("t1_awvalid", awvalid_o, 1);
        check("t1_awaddr", awaddr_o, 32'h1000);
        check("t1_awlen", awlen_o, 3);
        check("t1_awburst", awburst_o, 2'b01);
        check("t1_req_ready", req_ready_o, 1);
        check("t1_not_idle", idle_o, 0);
        step();
        req_valid_i = 1'b0;
        #1;
        check("t1_no_w_before_load", wvalid_o, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            buf_data_i = 32'hA0 + i;
            #1;
            check("t1_wvalid", wvalid_o, 1);
            check("t1_wdata", wdata_o, 32'hA0 + i);
            check("t1_wstrb", wstrb_o, 4'hF);
            check("t1_wlast", wlast_o, (i == 3));
            step();
        end
        check("t1_w_done", wvalid_o, 0);
        check("t1_bready", bready_o, 1);
        check("t1_idle_wait_b", idle_o, 0);
        b_ok();
        #1;
        check("t1_idle", idle_o, 1);
        check("t1_err", err_o, 0);

        // Unaligned single beat
        set_req(32'h2002, 8'd0, 4'hC, 1'b1);
        #1;
        check("t2_awaddr", awaddr_o, 32'h2002);
        check("t2_req_ready", req_ready_o, 1);
        step();
        req_valid_i = 1'b0;
        step();
        buf_data_i = 32'h55;
        #1;
        check("t2_wvalid", wvalid_o, 1);
        check("t2_wstrb", wstrb_o, 4'hC);
        check("t2_wlast", wlast_o, 1);
        check("t2_wdata", wdata_o, 32'h55);
        step();
        check("t2_w_done", wvalid_o, 0);
        b_ok();

        // FIXED, 16 beats
        set_req(32'h3000, 8'd15, 4'hF, 1'b0);
        #1;
        check("t3_awburst", awburst_o, 2'b00);
        check("t3_awlen", awlen_o, 15);
        step();
        req_valid_i = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            buf_data_i = i;
            #1;
            check("t3_wvalid", wvalid_o, 1);
            check("t3_wlast", wlast_o, (i == 15));
            step();
        end
        check("t3_w_done", wvalid_o, 0);
        b_ok();
        #1;
        check("t3_idle", idle_o, 1);

        // Four outstanding with B withheld; fifth stalls; W bursts chain
        for (int k = 0; k < 4; k++) begin
            set_req(32'h4000 + 32'(k) * 32'h10, 8'd1, 4'hF, 1'b1);
            #1;
            check("t4_awvalid_accept", awvalid_o, 1);
            step();
        end
        set_req(32'h4040, 8'd1, 4'hF, 1'b1);
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t4_fifth_stalled", awvalid_o, 0);
            check("t4_wvalid_no_bubble", wvalid_o, 1);
            check("t4_wlast_pattern", wlast_o, (c % 2 == 1));
            step();
        end
        check("t4_w_drained", wvalid_o, 0);
        bvalid_i = 1'b1;
        bresp_i  = 2'b00;
        #1;
        check("t4_still_stalled", awvalid_o, 0);
        step();
        bvalid_i = 1'b0;
        #1;
        check("t4_fifth_issued", awvalid_o, 1);
        step();
        req_valid_i = 1'b0;
        step(); step(); step();
        check("t4_fifth_w_done", wvalid_o, 0);
        for (int k = 0; k < 4; k++) b_ok();
        #1;
        check("t4_idle", idle_o, 1);

        // Backpressure on both buffer and W
        set_req(32'h5000, 8'd3, 4'h3, 1'b1);
        step();
        req_valid_i = 1'b0;
        step();
        idx = 0;
        for (int c = 0; c < 12 && idx < 4; c++) begin
            buf_valid_i = bv[c][0];
            wready_i    = wr[c][0];
            buf_data_i  = dseq[idx];
            #1;
            check("t5_wvalid", wvalid_o, bv[c][0]);
            check("t5_buf_ready", buf_ready_o, wr[c][0]);
            if (bv[c] != 0) begin
                check("t5_wdata", wdata_o, dseq[idx]);
                check("t5_wstrb", wstrb_o, 4'h3);
                check("t5_wlast", wlast_o, (idx == 3));
            end
            step();
            if (bv[c] != 0 && wr[c] != 0) idx++;
        end
        check("t5_all_beats", idx, 4);
        buf_valid_i = 1'b1;
        wready_i    = 1'b1;
        #1;
        check("t5_w_done", wvalid_o, 0);
        b_ok();

        // Abort after first request; SLVERR; sticky error
        set_req(32'h6000, 8'd0, 4'hF, 1'b1);
        step();
        set_req(32'h7000, 8'd0, 4'hF, 1'b1);
        dma_abort_i = 1'b1;
        #1;
        check("t6_abort_awvalid", awvalid_o, 0);
        check("t6_abort_req_ready", req_ready_o, 0);
        step();
        check("t6_first_w", wvalid_o, 1);
        check("t6_first_wlast", wlast_o, 1);
        step();
        check("t6_w_done", wvalid_o, 0);
        bvalid_i = 1'b1;
        bresp_i  = 2'b10;
        #1;
        check("t6_bready", bready_o, 1);
        step();
        bvalid_i = 1'b0;
        bresp_i  = 2'b00;
        check("t6_err_set", err_o, 1);
        check("t6_idle", idle_o, 1);
        check("t6_still_blocked", awvalid_o, 0);
        step();
        check("t6_err_sticky", err_o, 1);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        check("t6_err_cleared", err_o, 0);
        dma_abort_i = 1'b0;
        req_valid_i = 1'b0;
        #1;
        check("t6_final_idle", idle_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
